imu_sequencer: RTL and testbench
================================

IMU_SEQUENCER -- requirements
Module: imu_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 100000, clk cycles between sample bursts (>=16).
REQ-002 SHALL have parameter ID_RETRY, default 3, WHO_AM_I attempts before error.
REQ-003 SHALL have port clk  input  1  sole clock (SPI-domain clock).
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_en  input  1  enables periodic sampling.
REQ-006 SHALL have port spi_req  output  1  byte-transaction request to SPI engine.
REQ-007 SHALL have port spi_wr  output  1  1=write, 0=read.
REQ-008 SHALL have port spi_addr  output  7  IMU register address.
REQ-009 SHALL have port spi_wdata  output  8  write byte.
REQ-010 SHALL have port spi_ack  input  1  one-cycle pulse: transaction done, spi_rdata valid.
REQ-011 SHALL have port spi_rdata  input  8  read byte.
REQ-012 SHALL have port curr_data  output  96  latest sample, byte k at [8k+7:8k].
REQ-013 SHALL have port data_valid  output  1  one-cycle pulse on curr_data update.
REQ-014 SHALL have port busy  output  1  high whenever state is not WAIT or IDLE.
REQ-015 SHALL have port err  output  1  sticky ID-check failure.

Function
REQ-016 SHALL implement states IDLE, ID_CHK, CFG, WAIT, READ, PUBLISH, ERR.
REQ-017 SHALL leave IDLE on the first cycle after reset release, to ID_CHK.
REQ-018 ID_CHK SHALL read 0x0F; 0x69 -> CFG; mismatch retries, ID_RETRY-th mismatch -> ERR.
REQ-019 CFG SHALL write 0x10<=0x40 then 0x11<=0x40, then -> WAIT.
REQ-020 WAIT SHALL count SAMPLE_DIV-1 down to 0; at 0 with start_en=1 -> READ, else reload and stay.
REQ-021 READ SHALL issue 12 sequential reads, addresses 0x22..0x2D, byte k into shadow slot k.
REQ-022 PUBLISH SHALL copy shadow to curr_data and pulse data_valid in one cycle, then -> WAIT with counter reloaded.
REQ-023 curr_data SHALL change only in PUBLISH; partial bursts never visible.
REQ-024 Handshake: spi_req, spi_wr, spi_addr, spi_wdata SHALL be stable from req rise until ack.
REQ-025 spi_req SHALL drop the cycle after ack and stay low at least one cycle before next request.
REQ-026 spi_ack while spi_req=0 SHALL be ignored.
REQ-027 start_en falling during READ SHALL NOT abort the burst; it completes and publishes.
REQ-028 ERR SHALL be terminal until reset; err=1, spi_req=0.
REQ-029 spi_wdata SHALL be 0 during reads.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, spi_req=0, spi_wr=0, spi_addr=0, spi_wdata=0, curr_data=0, data_valid=0, busy=0, err=0, counters and shadow cleared.
REQ-031 Reset mid-transaction SHALL abandon it; no ack is awaited after release.

Configuration
REQ-032 With IMU_SEQ_IDCHK_EN defined, ID_CHK SHALL operate per REQ-018.
REQ-033 Without IMU_SEQ_IDCHK_EN, IDLE SHALL go directly to CFG; err tied 0; ERR unreachable.

Structure
REQ-034 Package imu_seq_pkg SHALL hold the state enum, register addresses (0x0F, 0x10, 0x11, 0x22), config bytes (0x40), WHO_AM_I value 0x69, burst length 12.
REQ-035 Sub-module sample_timer SHALL implement the SAMPLE_DIV reload/down-counter with load and zero outputs.

Verification
REQ-036 Reset release, responder returns 0x69 -> reads 0x0F, writes (0x10,0x40),(0x11,0x40), enters WAIT.
REQ-037 SAMPLE_DIV=16, start_en=1, responder returns 0xA0+k for addr 0x22+k -> curr_data bytes 0xA0..0xAB, one data_valid pulse, next burst 16 cycles after PUBLISH.
REQ-038 Responder returns 0x00 three times (ID_RETRY=3) -> err=1, spi_req stays 0 thereafter.
REQ-039 start_en dropped after byte 5 -> all 12 reads complete, data_valid pulses, no further bursts.
REQ-040 rst_n asserted while spi_req=1 in READ -> all outputs 0 same cycle; after release sequence restarts at ID_CHK.
REQ-041 Spurious spi_ack pulses in WAIT -> no state, output or counter change.

Source files
------------

// File: rtl/imu_sequencer_pkg.sv
// imu_seq_pkg: shared definitions for the IMU sampling sequencer.
//   - state_e        : sequencer FSM states
//   - Addr*          : IMU register addresses used by the sequencer
//   - CfgByte        : value written to both control registers
//   - WhoAmIVal      : expected WHO_AM_I response
//   - BurstLen/IdxW  : bytes per sample burst and width of the byte index
//   - burst_addr()   : register address of burst byte k
package imu_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIdChk,
      StCfg,
      StWait,
      StRead,
      StPublish,
      StErr
   } state_e;

   localparam logic [6:0] AddrWhoAmI = 7'h0F;
   localparam logic [6:0] AddrCtrl1  = 7'h10;
   localparam logic [6:0] AddrCtrl2  = 7'h11;
   localparam logic [6:0] AddrBurst  = 7'h22;

   localparam logic [7:0] CfgByte    = 8'h40;
   localparam logic [7:0] WhoAmIVal  = 8'h69;

   localparam int unsigned BurstLen  = 12;
   localparam int unsigned IdxW      = 4;

   function automatic logic [6:0] burst_addr(input logic [IdxW-1:0] idx);
      return AddrBurst + {3'b000, idx};
   endfunction

endpackage

// File: rtl/imu_sequencer_if.sv
// imu_sequencer_if: byte-transaction handshake between the sequencer and an SPI engine.
//   spi_req   : transaction request (sequencer -> engine)
//   spi_wr    : 1 = write, 0 = read
//   spi_addr  : 7-bit IMU register address
//   spi_wdata : write byte (0 during reads)
//   spi_ack   : one-cycle completion pulse, spi_rdata valid with it (engine -> sequencer)
//   spi_rdata : read byte
// Modports: master (sequencer side), slave (engine side).
interface imu_sequencer_if;

   logic       spi_req;
   logic       spi_wr;
   logic [6:0] spi_addr;
   logic [7:0] spi_wdata;
   logic       spi_ack;
   logic [7:0] spi_rdata;

   modport master (
      output spi_req,
      output spi_wr,
      output spi_addr,
      output spi_wdata,
      input  spi_ack,
      input  spi_rdata
   );

   modport slave (
      input  spi_req,
      input  spi_wr,
      input  spi_addr,
      input  spi_wdata,
      output spi_ack,
      output spi_rdata
   );

endinterface

// File: rtl/imu_sequencer_sample_timer.sv
// sample_timer: reloadable down-counter that paces sample bursts.
//   clk, rst_n : clock, asynchronous active-low reset (count cleared to 0)
//   load       : reload the count with SAMPLE_DIV-1
//   zero       : count has reached 0 (it then holds until the next load)
module sample_timer #(
   parameter int unsigned SAMPLE_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic zero
);

   localparam int unsigned CountW = $clog2(SAMPLE_DIV);

   logic [CountW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= CountW'(SAMPLE_DIV - 1);
      end else if (count_q != '0) begin
         count_q <= count_q - CountW'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/imu_sequencer.sv
// imu_sequencer: brings up an IMU over a byte-oriented SPI engine and samples it periodically.
// After reset it checks WHO_AM_I (optional), writes the two control registers, then every
// SAMPLE_DIV cycles (while start_en) reads a 12-byte burst and publishes it atomically.
//   clk, rst_n  : sole clock, asynchronous active-low reset
//   start_en    : enables periodic sampling
//   spi         : imu_sequencer_if.master transaction port
//   curr_data   : latest complete sample, byte k at [8k+7:8k]
//   data_valid  : one-cycle pulse coinciding with a curr_data update
//   busy        : high outside WAIT and IDLE
//   err         : sticky WHO_AM_I failure
// Build option: define IMU_SEQ_IDCHK_EN to enable the WHO_AM_I check; otherwise IDLE goes
// straight to CFG and err is tied low.
module imu_sequencer
   import imu_seq_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 100000,
   parameter int unsigned ID_RETRY   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_en,
   imu_sequencer_if.master       spi,
   output logic [8*BurstLen-1:0] curr_data,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned       RetryW    = (ID_RETRY > 1) ? $clog2(ID_RETRY) : 1;
   localparam logic [RetryW-1:0] RetryLast = RetryW'(ID_RETRY - 1);

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [RetryW-1:0]     retry_q, retry_d;
   logic [8*BurstLen-1:0] shadow_q, shadow_d;
   logic [8*BurstLen-1:0] curr_data_q;
   logic                  data_valid_q;
   logic                  req_q, req_d;
   logic                  wr_q, wr_d;
   logic [6:0]            addr_q, addr_d;
   logic [7:0]            wdata_q, wdata_d;
   logic                  txn_done;
   logic                  timer_load;
   logic                  timer_zero;

   // Acks outside an outstanding request are ignored.
   assign txn_done = req_q & spi.spi_ack;

   sample_timer #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_sample_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (timer_load),
      .zero  (timer_zero)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      retry_d    = retry_q;
      shadow_d   = shadow_q;
      timer_load = 1'b0;

      unique case (state_q)
         StIdle: begin
`ifdef IMU_SEQ_IDCHK_EN
            state_d = StIdChk;
`else
            state_d = StCfg;
`endif
         end
         StIdChk: begin
            if (txn_done) begin
               if (spi.spi_rdata == WhoAmIVal) begin
                  retry_d = '0;
                  state_d = StCfg;
               end else if (retry_q == RetryLast) begin
                  state_d = StErr;
               end else begin
                  retry_d = retry_q + RetryW'(1);
               end
            end
         end
         StCfg: begin
            if (txn_done) begin
               if (idx_q == IdxW'(1)) begin
                  idx_d      = '0;
                  timer_load = 1'b1;
                  state_d    = StWait;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         StWait: begin
            if (timer_zero) begin
               if (start_en) begin
                  state_d = StRead;
               end else begin
                  timer_load = 1'b1;
               end
            end
         end
         StRead: begin
            // start_en is deliberately not looked at: a started burst always completes.
            if (txn_done) begin
               shadow_d[{idx_q, 3'b000} +: 8] = spi.spi_rdata;
               if (idx_q == IdxW'(BurstLen - 1)) begin
                  idx_d   = '0;
                  state_d = StPublish;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         StPublish: begin
            timer_load = 1'b1;
            state_d    = StWait;
         end
         StErr: begin
            state_d = StErr;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Request fields are loaded when req rises and held until ack, then cleared. Issue is
   // decided from the next state so a WAIT->READ transition starts the first read at once;
   // since a completing request always drops first, req is low at least one cycle between
   // transactions.
   always_comb begin
      req_d   = req_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      if (req_q) begin
         if (spi.spi_ack) begin
            req_d   = 1'b0;
            wr_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
         end
      end else begin
         case (state_d)
            StIdChk: begin
               req_d   = 1'b1;
               wr_d    = 1'b0;
               addr_d  = AddrWhoAmI;
               wdata_d = '0;
            end
            StCfg: begin
               req_d   = 1'b1;
               wr_d    = 1'b1;
               addr_d  = (idx_d == '0) ? AddrCtrl1 : AddrCtrl2;
               wdata_d = CfgByte;
            end
            StRead: begin
               req_d   = 1'b1;
               wr_d    = 1'b0;
               addr_d  = burst_addr(idx_d);
               wdata_d = '0;
            end
            default: begin
               req_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         retry_q      <= '0;
         shadow_q     <= '0;
         curr_data_q  <= '0;
         data_valid_q <= 1'b0;
         req_q        <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         retry_q      <= retry_d;
         shadow_q     <= shadow_d;
         data_valid_q <= (state_q == StPublish);
         req_q        <= req_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         if (state_q == StPublish) begin
            curr_data_q <= shadow_q;
         end
      end
   end

   assign spi.spi_req   = req_q;
   assign spi.spi_wr    = wr_q;
   assign spi.spi_addr  = addr_q;
   assign spi.spi_wdata = wdata_q;

   assign curr_data  = curr_data_q;
   assign data_valid = data_valid_q;
   assign busy       = (state_q != StWait) && (state_q != StIdle);

`ifdef IMU_SEQ_IDCHK_EN
   assign err = (state_q == StErr);
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imu_sequencer.sv
// tb_imu_sequencer: directed bench for imu_sequencer with SAMPLE_DIV=16, ID_RETRY=3.
// A simple SPI engine model answers requests after a fixed latency and logs every completed
// transaction; a monitor watches handshake rules continuously.
module tb_imu_sequencer;

   localparam int unsigned SampleDiv = 16;
   localparam int unsigned IdRetry   = 3;
   localparam int          RspLat    = 2;

   typedef struct {
      logic       wr;
      logic [6:0] addr;
      logic [7:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_en;
   logic [95:0] curr_data;
   logic        data_valid;
   logic        busy;
   logic        err;

   logic        rsp_ack  = 1'b0;
   logic        spur_ack = 1'b0;
   logic [7:0]  rsp_rdata = 8'h00;
   logic [7:0]  rsp_base  = 8'hA0;
   logic [7:0]  who_resp  = 8'h69;
   int          lat = 0;
   txn_t        log_q[$];

   int          n_checks = 0;
   int          n_pass   = 0;

   // Monitor state
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic        cap_wr;
   logic [6:0]  cap_addr;
   logic [7:0]  cap_wdata;
   logic [95:0] prev_curr = '0;
   int          stab_viol  = 0;
   int          drop_viol  = 0;
   int          wdata_viol = 0;
   int          curr_viol  = 0;
   int          dv_count   = 0;
   int          err_seen   = 0;

   imu_sequencer_if spi_if ();

   assign spi_if.spi_ack   = rsp_ack | spur_ack;
   assign spi_if.spi_rdata = rsp_rdata;

   imu_sequencer #(
      .SAMPLE_DIV (SampleDiv),
      .ID_RETRY   (IdRetry)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_en   (start_en),
      .spi        (spi_if),
      .curr_data  (curr_data),
      .data_valid (data_valid),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rsp_data(input logic [6:0] a);
      if (a == 7'h0F) return who_resp;
      if (a >= 7'h22 && a <= 7'h2D) return rsp_base + {1'b0, a - 7'h22};
      return 8'h00;
   endfunction

   // SPI engine model: ack RspLat+1 falling edges after the request is seen.
   always @(negedge clk) begin
      rsp_ack = 1'b0;
      if (!spi_if.spi_req || !rst_n) begin
         lat = 0;
      end else if (lat == RspLat) begin
         rsp_ack   = 1'b1;
         rsp_rdata = rsp_data(spi_if.spi_addr);
         log_q.push_back('{wr: spi_if.spi_wr, addr: spi_if.spi_addr, wdata: spi_if.spi_wdata});
         lat = 0;
      end else begin
         lat++;
      end
   end

   // Handshake monitor, using pre-edge values at each rising edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         prev_req  <= 1'b0;
         prev_ack  <= 1'b0;
         prev_curr <= curr_data;
      end else begin
         if (spi_if.spi_req && !prev_req) begin
            cap_wr    <= spi_if.spi_wr;
            cap_addr  <= spi_if.spi_addr;
            cap_wdata <= spi_if.spi_wdata;
         end else if (spi_if.spi_req && (spi_if.spi_wr != cap_wr || spi_if.spi_addr != cap_addr
                      || spi_if.spi_wdata != cap_wdata)) begin
            stab_viol <= stab_viol + 1;
         end
         if (prev_ack && prev_req && spi_if.spi_req) drop_viol <= drop_viol + 1;
         if (spi_if.spi_req && !spi_if.spi_wr && spi_if.spi_wdata != 8'h00)
            wdata_viol <= wdata_viol + 1;
         if (curr_data != prev_curr && !data_valid) curr_viol <= curr_viol + 1;
         if (data_valid) dv_count <= dv_count + 1;
         if (err) err_seen <= err_seen + 1;
         prev_req  <= spi_if.spi_req;
         prev_ack  <= spi_if.spi_ack;
         prev_curr <= curr_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      int t;
      int cnt;
      int bad;
      int n_init;
      logic busy_mid;
      logic req_hi;

      rst_n    = 1'b0;
      start_en = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_req",   spi_if.spi_req,   1'b0);
      check("rst_wr",    spi_if.spi_wr,    1'b0);
      check("rst_addr",  spi_if.spi_addr,  7'h00);
      check("rst_wdata", spi_if.spi_wdata, 8'h00);
      check("rst_curr",  curr_data,        96'h0);
      check("rst_dv",    data_valid,       1'b0);
      check("rst_busy",  busy,             1'b0);
      check("rst_err",   err,              1'b0);

      // Bring-up sequence
      rst_n = 1'b1;
`ifdef IMU_SEQ_IDCHK_EN
      n_init = 3;
`else
      n_init = 2;
`endif
      t = 0;
      while (log_q.size() < n_init && t < 100) begin tick(); t++; end
      check("init_timeout", t < 100, 1'b1);
      check("init_count", log_q.size(), n_init);
      bad = 0;
`ifdef IMU_SEQ_IDCHK_EN
      if (log_q[0].wr !== 1'b0 || log_q[0].addr !== 7'h0F) bad++;
`endif
      if (log_q[n_init-2].wr !== 1'b1 || log_q[n_init-2].addr !== 7'h10 ||
          log_q[n_init-2].wdata !== 8'h40) bad++;
      if (log_q[n_init-1].wr !== 1'b1 || log_q[n_init-1].addr !== 7'h11 ||
          log_q[n_init-1].wdata !== 8'h40) bad++;
      check("init_txns", bad, 0);
      repeat (3) tick();
      check("wait_busy", busy, 1'b0);
      check("wait_req",  spi_if.spi_req, 1'b0);

      // First burst, 0xA0+k
      log_q.delete();
      start_en = 1'b1;
      t = 0;
      while (!data_valid && t < 200) begin tick(); t++; end
      check("burst1_timeout", t < 200, 1'b1);
      check("burst1_data", curr_data, 96'hABAAA9A8A7A6A5A4A3A2A1A0);
      check("burst1_len", log_q.size(), 12);
      bad = 0;
      for (int k = 0; k < 12 && k < log_q.size(); k++) begin
         if (log_q[k].wr !== 1'b0 || log_q[k].addr !== 7'(7'h22 + k) ||
             log_q[k].wdata !== 8'h00) bad++;
      end
      check("burst1_addrs", bad, 0);

      // Period to next burst with spurious acks injected in WAIT
      log_q.delete();
      rsp_base = 8'hB0;
      cnt      = 0;
      busy_mid = 1'b1;
      while (!spi_if.spi_req && cnt < 40) begin
         spur_ack = (cnt == 3 || cnt == 8 || cnt == 12);
         if (cnt == 5) busy_mid = busy;
         tick();
         cnt++;
      end
      spur_ack = 1'b0;
      check("period", cnt, 16);
      check("wait_busy_mid", busy_mid, 1'b0);
      check("dv_once", dv_count, 1);
      check("curr_hold", curr_data, 96'hABAAA9A8A7A6A5A4A3A2A1A0);

      // Drop start_en after byte 5: burst completes, then sampling stops
      t = 0;
      while (log_q.size() < 6 && t < 100) begin tick(); t++; end
      start_en = 1'b0;
      t = 0;
      while (!data_valid && t < 200) begin tick(); t++; end
      check("burst2_timeout", t < 200, 1'b1);
      check("burst2_data", curr_data, 96'hBBBAB9B8B7B6B5B4B3B2B1B0);
      check("burst2_len", log_q.size(), 12);
      repeat (60) tick();
      check("stop_len", log_q.size(), 12);
      check("stop_dv",  dv_count, 2);
      check("stop_busy", busy, 1'b0);

      // Reset while a burst read is outstanding
      start_en = 1'b1;
      t = 0;
      while (!(spi_if.spi_req && spi_if.spi_addr == 7'h25) && t < 200) begin tick(); t++; end
      check("rd_timeout", t < 200, 1'b1);
      check("rd_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req",   spi_if.spi_req,   1'b0);
      check("arst_addr",  spi_if.spi_addr,  7'h00);
      check("arst_wr",    spi_if.spi_wr,    1'b0);
      check("arst_curr",  curr_data,        96'h0);
      check("arst_busy",  busy,             1'b0);
      check("arst_err",   err,              1'b0);
      check("arst_dv",    data_valid,       1'b0);
      start_en = 1'b0;
      repeat (3) tick();
      log_q.delete();
      rst_n = 1'b1;
      t = 0;
      while (log_q.size() < 1 && t < 50) begin tick(); t++; end
      check("restart_timeout", t < 50, 1'b1);
`ifdef IMU_SEQ_IDCHK_EN
      check("restart_first", {log_q[0].wr, log_q[0].addr}, {1'b0, 7'h0F});
`else
      check("restart_first", {log_q[0].wr, log_q[0].addr}, {1'b1, 7'h10});
`endif

`ifdef IMU_SEQ_IDCHK_EN
      // WHO_AM_I mismatch on every attempt
      rst_n    = 1'b0;
      who_resp = 8'h00;
      repeat (2) tick();
      log_q.delete();
      rst_n = 1'b1;
      t = 0;
      while (!err && t < 100) begin tick(); t++; end
      check("err_timeout", t < 100, 1'b1);
      check("err_flag", err, 1'b1);
      check("err_tries", log_q.size(), 3);
      bad = 0;
      foreach (log_q[k]) if (log_q[k].addr !== 7'h0F) bad++;
      check("err_addrs", bad, 0);
      log_q.delete();
      req_hi = 1'b0;
      repeat (40) begin
         tick();
         if (spi_if.spi_req) req_hi = 1'b1;
      end
      check("err_req_low", req_hi, 1'b0);
      check("err_sticky", err, 1'b1);
      check("err_busy", busy, 1'b1);
      check("err_no_txn", log_q.size(), 0);
`else
      check("err_never", err_seen, 0);
`endif

      check("hs_stable", stab_viol, 0);
      check("hs_drop", drop_viol, 0);
      check("rd_wdata_zero", wdata_viol, 0);
      check("curr_atomic", curr_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
